// File: rtl/rs232_tx.sv
// rs232_tx: UART transmitter, 8 data bits LSB first, one-entry holding buffer, zero-gap back-to-back frames.
// Define RS232_TX_PARITY_EN to insert an even-parity bit after D7 (11-bit frame).
module rs232_tx #(
    parameter int baud = 9600,
    parameter int mhz  = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] transmit_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       RS232_DCE_TXD
);
    localparam int BIT_PER = (mhz * 1_000_000) / baud;
    localparam int CW = $clog2(BIT_PER);
    localparam logic [CW-1:0] LAST = CW'(BIT_PER - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef RS232_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] buf_q, buf_d, sh_q, sh_d;
    logic full_q, full_d, rdy_q, txd_q, txd_d, busy_q, busy_d, done_q, done_d;
    logic last, accept, load;

    assign last   = cnt_q == LAST;
    assign accept = tx_vld && rdy_q;
    // The buffer drains into the shifter when a frame starts, from IDLE or straight out of the last STOP cycle.
    assign load   = full_q && (state_q == IDLE || (state_q == STOP && last));

    assign tx_rdy        = rdy_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign RS232_DCE_TXD = txd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            sh_q    <= '0;
            rdy_q   <= 1'b1;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            sh_q    <= sh_d;
            rdy_q   <= ~full_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = full_q ? START : IDLE;
            START:   state_d = last ? DATA : START;
            DATA:    state_d = last && idx_q == 3'd7 ? AFTER_DATA : DATA;
            PARITY:  state_d = last ? STOP : PARITY;
            STOP:    state_d = last ? (full_q ? START : IDLE) : STOP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = state_q == IDLE || last ? '0 : cnt_q + CW'(1);
        idx_d  = state_q == DATA && last ? idx_q + 3'd1 : idx_q;
        full_d = accept ? 1'b1 : load ? 1'b0 : full_q;
        buf_d  = accept ? transmit_data : buf_q;
        sh_d   = load ? buf_q : sh_q;
    end

    // Line outputs are registered, so they trail the state by one cycle.
    always_comb begin
        txd_d  = state_q == START ? 1'b0 : state_q == DATA ? sh_q[idx_q] : state_q == PARITY ? ^sh_q : 1'b1;
        busy_d = state_q != IDLE;
        done_d = state_q == STOP && last;
    end
endmodule

// File: tb/tb_rs232_tx.sv
// tb_rs232_tx: bench for rs232_tx at 8 MHz / 1 Mbaud (8 clocks per bit).
module tb_rs232_tx;
    localparam int BP = 8;
`ifdef RS232_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * BP;

    logic clock = 1'b0, reset = 1'b1, tx_vld = 1'b0;
    logic [7:0] transmit_data = 8'h00;
    logic tx_rdy, tx_busy, tx_done, RS232_DCE_TXD;

    rs232_tx #(.baud(1_000_000), .mhz(8)) dut (
        .clock(clock),
        .reset(reset),
        .transmit_data(transmit_data),
        .tx_vld(tx_vld),
        .tx_rdy(tx_rdy),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .RS232_DCE_TXD(RS232_DCE_TXD)
    );

    always #5 clock = ~clock;

    typedef struct { logic [7:0] d; int st; } frame_t;
    typedef struct { logic [7:0] d; logic [10:0] line; } vec_t;

    int checks = 0, failures = 0;
    int ec = 0, last_end = 0;
    bit rst_prev = 1'b0, in_fr = 1'b0;
    frame_t mq[$];
    frame_t cur;
    int acc_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, ec);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NB == 11 && k == 9) return ^d;
        return 1'b1;
    endfunction

    // Reference: a byte accepted at edge a starts on the line at edge max(a+2, end of previous frame).
    initial begin : logger
        int st;
        forever begin
            @(posedge clock);
            ec++;
            rst_prev = reset;
            if (reset) last_end = 0;
            else if (tx_vld && tx_rdy) begin
                st = ec + 2 > last_end ? ec + 2 : last_end;
                mq.push_back('{transmit_data, st});
                acc_log.push_back(ec);
                last_end = st + FL;
            end
        end
    end

    initial begin : monitor
        int p;
        logic rdy_exp;
        forever begin
            @(negedge clock);
            if (rst_prev) begin
                chk("rst_txd", RS232_DCE_TXD, 1);
                chk("rst_rdy", tx_rdy, 1);
                chk("rst_busy", tx_busy, 0);
                chk("rst_done", tx_done, 0);
                mq.delete();
                in_fr = 1'b0;
            end else begin
                if (!in_fr && mq.size() != 0 && mq[0].st == ec) begin
                    cur = mq.pop_front();
                    in_fr = 1'b1;
                end
                if (in_fr) begin
                    p = ec - cur.st;
                    chk("line_txd", RS232_DCE_TXD, line_bit(cur.d, p / BP));
                    chk("line_busy", tx_busy, 1);
                    chk("line_done", tx_done, p == FL - 1);
                    if (p == FL - 1) in_fr = 1'b0;
                end else begin
                    chk("idle_txd", RS232_DCE_TXD, 1);
                    chk("idle_busy", tx_busy, 0);
                    chk("idle_done", tx_done, 0);
                end
                rdy_exp = 1'b1;
                foreach (mq[i]) if (ec < mq[i].st - 1) rdy_exp = 1'b0;
                chk("rdy", tx_rdy, rdy_exp);
            end
        end
    end

    task automatic offer(input logic [7:0] d);
        int n = 0;
        @(negedge clock);
        while (!tx_rdy && n < 4 * FL) begin
            @(negedge clock);
            n++;
        end
        chk("offer_rdy", tx_rdy, 1);
        transmit_data = d;
        tx_vld = 1'b1;
        @(negedge clock);
        tx_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mq.size() != 0 || in_fr || tx_busy) && n < 4 * FL) begin
            @(negedge clock);
            n++;
        end
        chk("drain", n < 4 * FL, 1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        logic [7:0] seq[3];
        int n, nd, drops, t1, t2, a0;
`ifdef RS232_TX_PARITY_EN
        tbl[0] = '{8'h07, 11'h60E};
        tbl[1] = '{8'h03, 11'h406};
        tbl[2] = '{8'h55, 11'h4AA};
        tbl[3] = '{8'hFF, 11'h5FE};
        tbl[4] = '{8'h00, 11'h400};
`else
        tbl[0] = '{8'h55, 11'h2AA};
        tbl[1] = '{8'hA5, 11'h34A};
        tbl[2] = '{8'hFF, 11'h3FE};
        tbl[3] = '{8'h00, 11'h200};
        tbl[4] = '{8'h3C, 11'h278};
`endif
        seq = '{8'h11, 8'h22, 8'h33};
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        foreach (tbl[i]) begin
            wait_idle();
            offer(tbl[i].d);
            @(negedge clock);
            nd = 0;
            n = -1;
            for (int c = 1; c <= FL; c++) begin
                @(negedge clock);
                if ((c - 1) % BP == BP / 2) chk("vec_bit", RS232_DCE_TXD, tbl[i].line[(c - 1) / BP]);
                if (tx_done) begin
                    nd++;
                    n = c;
                end
            end
            chk("vec_done_cnt", nd, 1);
            chk("vec_done_pos", n, FL);
        end

        wait_idle();
        offer(8'hA5);
        repeat (28) @(negedge clock);
        chk("b2b_rdy_in_data", tx_rdy, 1);
        a0 = acc_log.size();
        offer(8'h3C);
        chk("b2b_accepted", acc_log.size() - a0, 1);
        nd = 0;
        drops = 0;
        t1 = 0;
        t2 = 0;
        for (int c = 0; c < 3 * FL && nd < 2; c++) begin
            @(negedge clock);
            if (tx_done) begin
                nd++;
                if (nd == 1) t1 = ec;
                else t2 = ec;
            end else if (!tx_busy) drops++;
        end
        chk("b2b_dones", nd, 2);
        chk("b2b_gap", t2 - t1, FL);
        chk("b2b_busy_drops", drops, 0);

        wait_idle();
        a0 = acc_log.size();
        for (int i = 0; i < 3; i++) begin
            transmit_data = seq[i];
            tx_vld = 1'b1;
            @(posedge clock);
            n = 0;
            @(negedge clock);
            while (!tx_rdy && n < 4 * FL) begin
                @(negedge clock);
                n++;
            end
            chk("seq_wait", n < 4 * FL, 1);
        end
        tx_vld = 1'b0;
        chk("seq_acc", acc_log.size() - a0, 3);
        if (acc_log.size() - a0 == 3) begin
            chk("seq_gap01", acc_log[a0+1] - acc_log[a0], 2);
            chk("seq_gap12", acc_log[a0+2] - acc_log[a0+1], FL);
        end
        wait_idle();

        offer(8'hFF);
        offer(8'h0F);
        repeat (35) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_txd", RS232_DCE_TXD, 1);
        chk("abort_rdy", tx_rdy, 1);
        nd = 0;
        for (int c = 0; c < 3 * FL; c++) begin
            @(negedge clock);
            if (tx_done) nd++;
        end
        chk("abort_no_done", nd, 0);

        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2 * FL)) @(negedge clock);
            offer(8'($urandom));
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
